// File: rtl/fft_pkg.sv
// Shared widths, latency and sample type for the waterfall FFT datapath.
package fft_pkg;

    localparam int FFT_ADDR_W   = 9;
    localparam int FFT_TW_W     = 8;
    localparam int FFT_SAMPLE_W = 16;
    localparam int BFLY_LATENCY = 4;

    typedef struct packed {
        logic signed [FFT_SAMPLE_W-1:0] re;
        logic signed [FFT_SAMPLE_W-1:0] im;
    } cplx_t;

endpackage

// File: rtl/fft_butterfly_if.sv
// Sequencer/ROM/write-back bus of the radix-2 butterfly; the master side issues pairs and serves the ROM.
interface fft_butterfly_if
    import fft_pkg::*;
#(
    parameter int addr_w   = FFT_ADDR_W,
    parameter int data_w   = FFT_TW_W,
    parameter int sample_w = FFT_SAMPLE_W
);

    logic                       in_valid;
    logic signed [sample_w-1:0] in_a_re;
    logic signed [sample_w-1:0] in_a_im;
    logic signed [sample_w-1:0] in_b_re;
    logic signed [sample_w-1:0] in_b_im;
    logic        [addr_w-1:0]   in_tw_idx;
    logic        [addr_w-1:0]   tw_addr;
    logic signed [data_w-1:0]   tw_real;
    logic signed [data_w-1:0]   tw_imag;
    logic                       out_valid;
    logic signed [sample_w-1:0] out0_re;
    logic signed [sample_w-1:0] out0_im;
    logic signed [sample_w-1:0] out1_re;
    logic signed [sample_w-1:0] out1_im;
    logic                       busy;

    modport master (
        output in_valid, in_a_re, in_a_im, in_b_re, in_b_im, in_tw_idx,
        output tw_real, tw_imag,
        input  tw_addr, out_valid, out0_re, out0_im, out1_re, out1_im, busy
    );

    modport slave (
        input  in_valid, in_a_re, in_a_im, in_b_re, in_b_im, in_tw_idx,
        input  tw_real, tw_imag,
        output tw_addr, out_valid, out0_re, out0_im, out1_re, out1_im, busy
    );

endinterface

// File: rtl/fft_cmul.sv
// Butterfly stages S2-S3: complex multiply B*W, scale by 2^-(data_w-1), with A carried alongside.
// Define BUTTERFLY_ROUND_EN for round-half-up scaling instead of truncation.
module fft_cmul
    import fft_pkg::*;
#(
    parameter int data_w   = FFT_TW_W,
    parameter int sample_w = FFT_SAMPLE_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic signed [sample_w-1:0] in_a_re,
    input  logic signed [sample_w-1:0] in_a_im,
    input  logic signed [sample_w-1:0] in_b_re,
    input  logic signed [sample_w-1:0] in_b_im,
    input  logic signed [data_w-1:0]   tw_re,
    input  logic signed [data_w-1:0]   tw_im,
    output logic                       out_valid,
    output logic                       busy,
    output logic signed [sample_w-1:0] out_a_re,
    output logic signed [sample_w-1:0] out_a_im,
    output logic signed [sample_w:0]   out_p_re,
    output logic signed [sample_w:0]   out_p_im
);

    localparam int prod_w = sample_w + data_w;
    localparam int sum_w  = prod_w + 1;

    logic                       s2_valid_d, s2_valid_q;
    logic signed [prod_w-1:0]   s2_rr_d, s2_rr_q, s2_ii_d, s2_ii_q;
    logic signed [prod_w-1:0]   s2_ri_d, s2_ri_q, s2_ir_d, s2_ir_q;
    logic signed [sample_w-1:0] s2_a_re_d, s2_a_re_q, s2_a_im_d, s2_a_im_q;

    logic                       s3_valid_d, s3_valid_q;
    logic signed [sum_w-1:0]    re_sum, im_sum;
    logic signed [sample_w:0]   s3_p_re_d, s3_p_re_q, s3_p_im_d, s3_p_im_q;
    logic signed [sample_w-1:0] s3_a_re_d, s3_a_re_q, s3_a_im_d, s3_a_im_q;

    function automatic logic signed [prod_w-1:0] smul(
        input logic signed [sample_w-1:0] b,
        input logic signed [data_w-1:0]   w
    );
        logic signed [prod_w-1:0] be;
        logic signed [prod_w-1:0] we;
        be = {{data_w{b[sample_w-1]}}, b};
        we = {{sample_w{w[data_w-1]}}, w};
        return be * we;
    endfunction

    // |B*W| < 2^(prod_w) and the twiddle is at most 127/128, so the scaled sum fits sample_w+1 bits.
    function automatic logic signed [sample_w:0] scale(input logic signed [sum_w-1:0] x);
        logic signed [sum_w-1:0] r;
`ifdef BUTTERFLY_ROUND_EN
        r = (x + (sum_w'(1) <<< (data_w - 2))) >>> (data_w - 1);
`else
        r = x >>> (data_w - 1);
`endif
        return (sample_w + 1)'(r);
    endfunction

    always_comb begin
        s2_valid_d = in_valid;
        s2_rr_d    = s2_rr_q;
        s2_ii_d    = s2_ii_q;
        s2_ri_d    = s2_ri_q;
        s2_ir_d    = s2_ir_q;
        s2_a_re_d  = s2_a_re_q;
        s2_a_im_d  = s2_a_im_q;
        if (in_valid) begin
            s2_rr_d   = smul(in_b_re, tw_re);
            s2_ii_d   = smul(in_b_im, tw_im);
            s2_ri_d   = smul(in_b_re, tw_im);
            s2_ir_d   = smul(in_b_im, tw_re);
            s2_a_re_d = in_a_re;
            s2_a_im_d = in_a_im;
        end
    end

    always_comb begin
        re_sum     = {s2_rr_q[prod_w-1], s2_rr_q} - {s2_ii_q[prod_w-1], s2_ii_q};
        im_sum     = {s2_ri_q[prod_w-1], s2_ri_q} + {s2_ir_q[prod_w-1], s2_ir_q};
        s3_valid_d = s2_valid_q;
        s3_p_re_d  = s3_p_re_q;
        s3_p_im_d  = s3_p_im_q;
        s3_a_re_d  = s3_a_re_q;
        s3_a_im_d  = s3_a_im_q;
        if (s2_valid_q) begin
            s3_p_re_d = scale(re_sum);
            s3_p_im_d = scale(im_sum);
            s3_a_re_d = s2_a_re_q;
            s3_a_im_d = s2_a_im_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s3_valid_q <= s3_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        s2_rr_q   <= s2_rr_d;
        s2_ii_q   <= s2_ii_d;
        s2_ri_q   <= s2_ri_d;
        s2_ir_q   <= s2_ir_d;
        s2_a_re_q <= s2_a_re_d;
        s2_a_im_q <= s2_a_im_d;
        s3_p_re_q <= s3_p_re_d;
        s3_p_im_q <= s3_p_im_d;
        s3_a_re_q <= s3_a_re_d;
        s3_a_im_q <= s3_a_im_d;
    end

    assign out_valid = s3_valid_q;
    assign busy      = s2_valid_q | s3_valid_q;
    assign out_a_re  = s3_a_re_q;
    assign out_a_im  = s3_a_im_q;
    assign out_p_re  = s3_p_re_q;
    assign out_p_im  = s3_p_im_q;

endmodule

// File: rtl/fft_butterfly.sv
// Pipelined radix-2 DIT butterfly: outputs (A+W*B)/2 and (A-W*B)/2, saturated, four cycles after input.
// Define BUTTERFLY_ROUND_EN for round-half-up at both scaling points instead of truncation.
module fft_butterfly
    import fft_pkg::*;
#(
    parameter int data_w   = FFT_TW_W,
    parameter int sample_w = FFT_SAMPLE_W
) (
    input  logic           clk,
    input  logic           reset,
    fft_butterfly_if.slave bus
);

    localparam int p_w = sample_w + 1;
    localparam int s_w = sample_w + 2;

    logic                       s1_valid_d, s1_valid_q;
    logic signed [sample_w-1:0] s1_a_re_d, s1_a_re_q, s1_a_im_d, s1_a_im_q;
    logic signed [sample_w-1:0] s1_b_re_d, s1_b_re_q, s1_b_im_d, s1_b_im_q;

    logic                       s3_valid, cmul_busy;
    logic signed [sample_w-1:0] s3_a_re, s3_a_im;
    logic signed [p_w-1:0]      s3_p_re, s3_p_im;

    logic                       s4_valid_d, s4_valid_q;
    logic signed [sample_w-1:0] out0_re_d, out0_re_q, out0_im_d, out0_im_q;
    logic signed [sample_w-1:0] out1_re_d, out1_re_q, out1_im_d, out1_im_q;

    // Halve A+/-p and clamp; the shifted sum still has two guard bits above the output width.
    function automatic logic signed [sample_w-1:0] bfly_half(
        input logic signed [sample_w-1:0] a,
        input logic signed [p_w-1:0]      p,
        input logic                       sub
    );
        logic signed [s_w-1:0] sum;
        logic signed [s_w-1:0] half;
        sum = sub ? ({{2{a[sample_w-1]}}, a} - {p[p_w-1], p})
                  : ({{2{a[sample_w-1]}}, a} + {p[p_w-1], p});
`ifdef BUTTERFLY_ROUND_EN
        sum = sum + s_w'(1);
`endif
        half = sum >>> 1;
        if (half[s_w-1:sample_w-1] == '0 || half[s_w-1:sample_w-1] == '1) begin
            return half[sample_w-1:0];
        end
        return half[s_w-1] ? {1'b1, {(sample_w-1){1'b0}}} : {1'b0, {(sample_w-1){1'b1}}};
    endfunction

    assign bus.tw_addr = bus.in_tw_idx;

    always_comb begin
        s1_valid_d = bus.in_valid;
        s1_a_re_d  = s1_a_re_q;
        s1_a_im_d  = s1_a_im_q;
        s1_b_re_d  = s1_b_re_q;
        s1_b_im_d  = s1_b_im_q;
        if (bus.in_valid) begin
            s1_a_re_d = bus.in_a_re;
            s1_a_im_d = bus.in_a_im;
            s1_b_re_d = bus.in_b_re;
            s1_b_im_d = bus.in_b_im;
        end
    end

    fft_cmul #(
        .data_w   (data_w),
        .sample_w (sample_w)
    ) u_cmul (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s1_valid_q),
        .in_a_re   (s1_a_re_q),
        .in_a_im   (s1_a_im_q),
        .in_b_re   (s1_b_re_q),
        .in_b_im   (s1_b_im_q),
        .tw_re     (bus.tw_real),
        .tw_im     (bus.tw_imag),
        .out_valid (s3_valid),
        .busy      (cmul_busy),
        .out_a_re  (s3_a_re),
        .out_a_im  (s3_a_im),
        .out_p_re  (s3_p_re),
        .out_p_im  (s3_p_im)
    );

    always_comb begin
        s4_valid_d = s3_valid;
        out0_re_d  = out0_re_q;
        out0_im_d  = out0_im_q;
        out1_re_d  = out1_re_q;
        out1_im_d  = out1_im_q;
        if (s3_valid) begin
            out0_re_d = bfly_half(s3_a_re, s3_p_re, 1'b0);
            out0_im_d = bfly_half(s3_a_im, s3_p_im, 1'b0);
            out1_re_d = bfly_half(s3_a_re, s3_p_re, 1'b1);
            out1_im_d = bfly_half(s3_a_im, s3_p_im, 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s4_valid_q <= 1'b0;
            out0_re_q  <= '0;
            out0_im_q  <= '0;
            out1_re_q  <= '0;
            out1_im_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s4_valid_q <= s4_valid_d;
            out0_re_q  <= out0_re_d;
            out0_im_q  <= out0_im_d;
            out1_re_q  <= out1_re_d;
            out1_im_q  <= out1_im_d;
        end
    end

    always_ff @(posedge clk) begin
        s1_a_re_q <= s1_a_re_d;
        s1_a_im_q <= s1_a_im_d;
        s1_b_re_q <= s1_b_re_d;
        s1_b_im_q <= s1_b_im_d;
    end

    assign bus.out_valid = s4_valid_q;
    assign bus.out0_re   = out0_re_q;
    assign bus.out0_im   = out0_im_q;
    assign bus.out1_re   = out1_re_q;
    assign bus.out1_im   = out1_im_q;
    assign bus.busy      = s1_valid_q | cmul_busy | s4_valid_q;

endmodule
